mem_stream_reader: RTL and testbench

- Read-side controller placed directly in front of the pseudo-2-port `memory` block.
- Takes a (base, length) request, drives the memory read port one word per cycle, and streams the returned words downstream on a valid/ready interface.
- Memory read is combinational (0-cycle), so each word is captured into a 2-entry output FIFO in the same cycle the read is issued.
- `read_en` is asserted only for words that will actually be stored, so no read energy is wasted under backpressure.

---
 rtl/mem_stream_pkg.sv | 18 +
 rtl/mem_stream_reader_if.sv | 44 ++++
 rtl/stream_fifo.sv | 70 +++++++
 rtl/mem_stream_reader.sv | 166 ++++++++++++++++
 tb/tb_mem_stream_reader.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stream_pkg.sv
// mem_stream_pkg: shared types and constants for the memory stream reader.
//   stream_state_t : controller FSM states (IDLE, STREAM, DRAIN, DONE)
//   FIFO_DEPTH     : number of entries in the output buffer
//   FIFO_CNT_W     : width of the buffer occupancy count (holds 0..FIFO_DEPTH)
package mem_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } stream_state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

endpackage

// File: rtl/mem_stream_reader_if.sv
// mem_stream_reader_if: bundles the memory read port and the downstream
// word stream of the memory stream reader.
//   mem_read_addr / mem_read_en : read request to the memory
//   mem_qout                    : read data, valid in the same cycle as mem_read_en
//   out_data / out_valid        : stream word offered downstream
//   out_ready                   : downstream accept
// Modports: master = the reader, slave = memory plus downstream consumer.
//
// Stream handshake: a word transfers on a rising clock edge where
// out_valid && out_ready. While out_valid is high, out_data is stable and
// out_valid does not drop until that transfer happens; out_ready may
// change freely and has no effect while out_valid is low.
interface mem_stream_reader_if #(
  parameter int  WIDTH  = 16,
  parameter int  HEIGHT = 128,
  localparam int ADDR_W = $clog2(HEIGHT)
);

  logic [ADDR_W-1:0] mem_read_addr;
  logic              mem_read_en;
  logic [WIDTH-1:0]  mem_qout;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_read_addr,
    output mem_read_en,
    input  mem_qout,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  mem_read_addr,
    input  mem_read_en,
    output mem_qout,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: small synchronous FIFO holding every word the reader has
// fetched but not yet handed downstream.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties and zeroes storage)
//   push       : write push_data at the tail (accepted if not full, or if
//                a pop happens in the same cycle)
//   push_data  : word to write
//   pop        : remove the head word (ignored when empty)
//   head       : current head word (registered storage, no bypass)
//   full/empty : occupancy flags
//   count      : number of stored words
module stream_fifo
  import mem_stream_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      store [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full  = (count == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = store[rd_ptr];

  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  function automatic logic [FIFO_PTR_W-1:0] ptr_inc(input logic [FIFO_PTR_W-1:0] p);
    ptr_inc = (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        store[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + FIFO_CNT_W'(1);
        2'b01:   count <= count - FIFO_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: read-side controller for a memory with a combinational
// read port. Accepts a (base, length) request, reads one word per cycle and
// streams the words downstream through a 2-entry FIFO. A read is only issued
// when its word has somewhere to go, so backpressure stalls the reads.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request strobe, only looked at while idle
//   base_addr  : first word address
//   length     : number of words (0..HEIGHT)
//   stride     : address step (only with MEM_STREAM_STRIDE_EN defined)
//   busy       : high whenever a request is in progress
//   done       : one-cycle pulse at request completion
//   dbg_state  : current FSM state
//   bus        : memory read port and output stream (master side)
// Build option: define MEM_STREAM_STRIDE_EN to add the stride input;
// otherwise addresses advance by 1.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int  WIDTH  = 16,
  parameter int  HEIGHT = 128,
  localparam int ADDR_W = $clog2(HEIGHT),
  localparam int LEN_W  = $clog2(HEIGHT) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
`ifdef MEM_STREAM_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  output logic              busy,
  output logic              done,
  output stream_state_t     dbg_state,
  mem_stream_reader_if.master bus
);

  stream_state_t state;
  stream_state_t state_next;

  logic [ADDR_W-1:0]     addr;
  logic [ADDR_W-1:0]     addr_next;
  logic [ADDR_W:0]       addr_sum;
  logic [ADDR_W-1:0]     step;
  logic [LEN_W-1:0]      issue_cnt;
  logic [LEN_W-1:0]      pop_cnt;

  logic                  issue;
  logic                  pop;
  logic                  accept;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [WIDTH-1:0]      fifo_head;

`ifdef MEM_STREAM_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;
  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif

  // Handshake and read-issue decisions.
  assign pop    = !fifo_empty && bus.out_ready;
  assign accept = (state == IDLE) && start && (length != '0);
  assign issue  = (state == STREAM) &&
                  ((fifo_count < FIFO_CNT_W'(FIFO_DEPTH)) || (fifo_full && pop));

  // Sum is formed one bit wider so the modulo is correct for any HEIGHT,
  // power of two or not.
  assign addr_sum  = {1'b0, addr} + {1'b0, step};
  assign addr_next = ADDR_W'(addr_sum % (ADDR_W + 1)'(HEIGHT));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (length != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        if (issue && (issue_cnt == LEN_W'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Finish as soon as the last outstanding word is leaving.
        if ((pop_cnt == '0) || ((pop_cnt == LEN_W'(1)) && pop)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address and counter datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
`ifdef MEM_STREAM_STRIDE_EN
      stride_q  <= '0;
`endif
    end else begin
      if (accept) begin
        addr      <= base_addr;
        issue_cnt <= length;
        pop_cnt   <= length;
`ifdef MEM_STREAM_STRIDE_EN
        stride_q  <= stride;
`endif
      end else begin
        if (issue) begin
          addr      <= addr_next;
          issue_cnt <= issue_cnt - LEN_W'(1);
        end
        if ((state != IDLE) && pop) begin
          pop_cnt <= pop_cnt - LEN_W'(1);
        end
      end
    end
  end

  stream_fifo #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (bus.mem_qout),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Address is forced to 0 on idle cycles so the memory never sees X.
  assign bus.mem_read_en   = issue;
  assign bus.mem_read_addr = issue ? addr : '0;
  assign bus.out_data      = fifo_head;
  assign bus.out_valid     = !fifo_empty;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: bench for mem_stream_reader with a behavioural
// memory, expected-address and expected-data queues filled at request time,
// and negedge monitors that pop and compare.
// Define MEM_STREAM_STRIDE_EN for both bench and RTL to exercise stride.
module tb_mem_stream_reader;
  import mem_stream_pkg::*;

  localparam int WIDTH  = 16;
  localparam int HEIGHT = 128;
  localparam int ADDR_W = $clog2(HEIGHT);
  localparam int LEN_W  = $clog2(HEIGHT) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
`ifdef MEM_STREAM_STRIDE_EN
  logic [ADDR_W-1:0] stride;
`endif
  logic              busy;
  logic              done;
  stream_state_t     dbg_state;

  mem_stream_reader_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();

  mem_stream_reader #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
`ifdef MEM_STREAM_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Behavioural memory with combinational read; junk when not enabled.
  logic [WIDTH-1:0] mem [HEIGHT];
  assign bus.mem_qout = bus.mem_read_en ? mem[bus.mem_read_addr] : 16'hdead;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ready_mode = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  bit valid_seen = 0;

  logic [WIDTH-1:0]  exp_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  int                read_cycles [$];
  int                pop_cycles [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_read_en) begin
        read_cycles.push_back(cyc);
        if (addr_q.size() == 0) fail_now("read_addr", $sformatf("unexpected read at 0x%0h", bus.mem_read_addr));
        else check("read_addr", 32'(bus.mem_read_addr), 32'(addr_q.pop_front()));
      end else begin
        check("idle_read_addr", 32'(bus.mem_read_addr), 32'd0);
      end
      if (bus.out_valid) valid_seen = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        pop_cycles.push_back(cyc);
        if (exp_q.size() == 0) fail_now("out_data", $sformatf("unexpected word 0x%0h", bus.out_data));
        else check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready();
    int rel;
    rel = cyc - start_cyc;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = !(rel >= 2 && rel <= 6);
    endcase
  endtask

  // Reference model: word k of a request lives at (base + k*stride) mod HEIGHT.
  task automatic issue_req(input int b, input int l, input int s);
    int a;
    read_cycles.delete();
    pop_cycles.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    valid_seen = 1'b0;
    for (int k = 0; k < l; k++) begin
      a = (b + k * s) % HEIGHT;
      addr_q.push_back(ADDR_W'(a));
      exp_q.push_back(mem[a]);
    end
    start_cyc = cyc;
    start     = 1'b1;
    base_addr = ADDR_W'(b);
    length    = LEN_W'(l);
`ifdef MEM_STREAM_STRIDE_EN
    stride    = ADDR_W'(s);
`endif
    set_ready();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int l, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      set_ready();
      tick();
      n++;
    end
    if (done_cnt == 0) begin
      fail_now({tag, "_timeout"}, "no done pulse within budget");
      exp_q.delete();
      addr_q.delete();
    end else begin
      bus.out_ready = 1'b1;
      tick();
      tick();
      check({tag, "_done_once"}, done_cnt, 1);
      check({tag, "_read_count"}, read_cycles.size(), l);
      check({tag, "_data_left"}, exp_q.size(), 0);
      check({tag, "_addr_left"}, addr_q.size(), 0);
      check({tag, "_idle"}, busy, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int b;
    int l;
    int s;
    int early;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    length = '0;
`ifdef MEM_STREAM_STRIDE_EN
    stride = '0;
`endif
    bus.out_ready = 1'b0;
    for (int i = 0; i < HEIGHT; i++) mem[i] = WIDTH'(i + 'h100);
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_read_en", bus.mem_read_en, 0);
    check("rst_read_addr", 32'(bus.mem_read_addr), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    tick();

    // Basic stream with latency checks.
    ready_mode = 0;
    issue_req(5, 4, 1);
    wait_done("basic", 4, 40);
    if (read_cycles.size() >= 4 && pop_cycles.size() >= 4) begin
      check("basic_first_read_cyc", read_cycles[0] - start_cyc, 1);
      check("basic_last_read_cyc", read_cycles[3] - start_cyc, 4);
      check("basic_first_out_cyc", pop_cycles[0] - start_cyc, 2);
      check("basic_last_out_cyc", pop_cycles[3] - start_cyc, 5);
    end else begin
      fail_now("basic_timing", "too few reads or outputs recorded");
    end

    // Backpressure: ready low for cycles 2..6, FIFO must stop at 2 words.
    ready_mode = 2;
    issue_req(0, 6, 1);
    wait_done("bp", 6, 60);
    early = 0;
    foreach (read_cycles[i]) if (read_cycles[i] - start_cyc <= 6) early++;
    check("bp_reads_while_stalled", early, 2);

    // Address wrap.
    ready_mode = 0;
    issue_req(126, 4, 1);
    wait_done("wrap", 4, 40);

    // Zero length.
    issue_req(3, 0, 1);
    wait_done("zero", 0, 10);
    check("zero_done_cyc", done_cyc - start_cyc, 1);
    check("zero_no_valid", valid_seen, 0);

    // Start while busy is ignored.
    issue_req(20, 8, 1);
    for (int i = 0; i < 3; i++) begin
      set_ready();
      tick();
    end
    start = 1'b1;
    base_addr = ADDR_W'(50);
    length = LEN_W'(3);
    tick();
    start = 1'b0;
    wait_done("busy_start", 8, 60);

    // Reset mid-stream after two reads.
    issue_req(40, 5, 1);
    n = 0;
    while (read_cycles.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    if (read_cycles.size() < 2) fail_now("midrst_wait", "reads never started");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_done", done, 0);
    check("midrst_read_en", bus.mem_read_en, 0);
    tick();
    tick();
    check("midrst_no_done", done_cnt, 0);
    issue_req(10, 2, 1);
    wait_done("after_rst", 2, 30);

`ifdef MEM_STREAM_STRIDE_EN
    issue_req(120, 3, 5);
    wait_done("stride", 3, 40);
    issue_req(7, 4, 0);
    wait_done("stride0", 4, 40);
`endif

    // Randomized requests with random data and random backpressure.
    for (int i = 0; i < HEIGHT; i++) mem[i] = WIDTH'($urandom);
    ready_mode = 1;
    for (int t = 0; t < 25; t++) begin
      b = $urandom_range(0, HEIGHT - 1);
      l = (t == 10) ? HEIGHT : $urandom_range(0, 24);
`ifdef MEM_STREAM_STRIDE_EN
      s = $urandom_range(0, HEIGHT - 1);
`else
      s = 1;
`endif
      issue_req(b, l, s);
      wait_done("rand", l, l * 12 + 30);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
